// File: rtl/seq_1011_framer.sv
// Serial frame transmitter: sync header 1,0,1,1 then payload MSB-first, one bit per clock.
// Optional trailing even-parity bit when SEQ_FRAMER_PARITY_EN is defined.
module seq_1011_framer #(
  parameter int unsigned PAYLOAD_W = 8,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 out_bit,
  output logic                 frame_active,
  output logic                 frame_done
);

  localparam int unsigned        CNT_W     = (PAYLOAD_W > 4) ? $clog2(PAYLOAD_W) : 2;
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0]   SYNC_LAST = CNT_W'(3);
  localparam logic [3:0]         SYNC_PAT  = 4'b1011;

`ifdef SEQ_FRAMER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0]   shift_q, shift_d;
  logic                   out_bit_q, out_bit_d;
  logic                   frame_active_q, frame_active_d;
  logic                   frame_done_q, frame_done_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [1:0]             sync_idx;
  logic                   accept;
`ifdef SEQ_FRAMER_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign data_ready   = (state_q == IDLE);
  assign accept       = data_valid & data_ready;
  assign out_bit      = out_bit_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    out_bit_d      = IDLE_BIT;
    frame_active_d = 1'b0;
    frame_done_d   = 1'b0;
    cnt_inc        = cnt_q + CNT_W'(1);
    sync_idx       = cnt_q[1:0] + 2'd1;
`ifdef SEQ_FRAMER_PARITY_EN
    parity_d       = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d        = SYNC;
          shift_d        = data_in;
          cnt_d          = '0;
          out_bit_d      = SYNC_PAT[3];
          frame_active_d = 1'b1;
`ifdef SEQ_FRAMER_PARITY_EN
          parity_d       = ^data_in;
`endif
        end
      end

      SYNC: begin
        frame_active_d = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          // Presents the payload MSB and pre-shifts so PAYLOAD always emits shift_q MSB.
          state_d   = PAYLOAD;
          cnt_d     = '0;
          out_bit_d = shift_q[PAYLOAD_W-1];
          shift_d   = shift_q << 1;
`ifndef SEQ_FRAMER_PARITY_EN
          frame_done_d = (LAST_CNT == '0);
`endif
        end else begin
          cnt_d     = cnt_inc;
          out_bit_d = SYNC_PAT[2'd3 - sync_idx];
        end
      end

      PAYLOAD: begin
        if (cnt_q == LAST_CNT) begin
`ifdef SEQ_FRAMER_PARITY_EN
          state_d        = PARITY;
          out_bit_d      = parity_q;
          frame_active_d = 1'b1;
          frame_done_d   = 1'b1;
`else
          state_d        = IDLE;
`endif
          cnt_d = '0;
        end else begin
          cnt_d          = cnt_inc;
          out_bit_d      = shift_q[PAYLOAD_W-1];
          shift_d        = shift_q << 1;
          frame_active_d = 1'b1;
`ifndef SEQ_FRAMER_PARITY_EN
          frame_done_d   = (cnt_inc == LAST_CNT);
`endif
        end
      end

`ifdef SEQ_FRAMER_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`endif

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      out_bit_q      <= IDLE_BIT;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
`ifdef SEQ_FRAMER_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      out_bit_q      <= out_bit_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
`ifdef SEQ_FRAMER_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_1011_framer.sv
// Scoreboard bench for seq_1011_framer: a frame-level model queues expected bits, a monitor checks every cycle.
module tb_seq_1011_framer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         out_bit;
  logic         frame_active;
  logic         frame_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit          exp_q[$];
  bit          cap_q[$];
  bit          model_busy = 1'b0;
  bit          mon_en = 1'b0;
  int unsigned acc_cnt = 0;
  int unsigned det_cnt = 0;
  logic [3:0]  det_sr = 4'b0000;

  always #5 clk = ~clk;

  seq_1011_framer #(.PAYLOAD_W(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .out_bit(out_bit),
    .frame_active(frame_active),
    .frame_done(frame_done)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a frame is header 1011, payload MSB-first, then optional even parity.
  task automatic push_frame(input logic [W-1:0] d);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_FRAMER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset_n === 1'b1 && data_valid === 1'b1 && !model_busy) begin
        push_frame(data_in);
        acc_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit eb, ea, ed, er;
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          ea = 1'b1;
          ed = (exp_q.size() == 0);
          er = 1'b0;
        end else begin
          eb = 1'b0;
          ea = 1'b0;
          ed = 1'b0;
          er = 1'b1;
        end
        model_busy = ea;
        check("cycle{out,active,done,ready}", {28'd0, out_bit, frame_active, frame_done, data_ready},
              {28'd0, eb, ea, ed, er});
        if (frame_active === 1'b1) cap_q.push_back(out_bit);
        det_sr = {det_sr[2:0], out_bit};
        if (det_sr == 4'b1011) det_cnt++;
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input bit drop);
    int unsigned start;
    bit got;
    start = acc_cnt;
    got = 1'b0;
    data_in = d;
    data_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_within_bound", {31'd0, got}, 32'd1);
    #1;
    if (drop) data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !model_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_within_bound", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] cap_tail(input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = cap_q.size() - n; i < cap_q.size(); i++) v = (v << 1) | 32'(cap_q[i]);
    return v;
  endfunction

  initial begin
    int unsigned det0;
    reset_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, out_bit, frame_active, frame_done, data_ready}, 32'h1);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);

    // Directed 0xA5 frame.
    cap_q.delete();
    send_word(8'hA5, 1'b1);
    wait_idle();
`ifdef SEQ_FRAMER_PARITY_EN
    check("a5_len", cap_q.size(), 32'd13);
    check("a5_stream", cap_tail(13), 32'h174A);
`else
    check("a5_len", cap_q.size(), 32'd12);
    check("a5_stream", cap_tail(12), 32'hBA5);
`endif

    // Back-to-back with data_valid held high; detector should fire once per header.
    cap_q.delete();
    det0 = det_cnt;
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b1);
    wait_idle();
    check("b2b_detects", det_cnt - det0, 32'd2);
`ifdef SEQ_FRAMER_PARITY_EN
    check("b2b_second", cap_tail(13), 32'h1600);
`else
    check("b2b_len", cap_q.size(), 32'd24);
    check("b2b_second", cap_tail(12), 32'hB00);
`endif

    // Asynchronous reset during payload bit 3 of 0xC3.
    send_word(8'hC3, 1'b1);
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    model_busy = 1'b0;
    #1;
    check("async_abort", {28'd0, out_bit, frame_active, frame_done, data_ready}, 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cap_q.delete();
    send_word(8'h3C, 1'b1);
    wait_idle();
`ifdef SEQ_FRAMER_PARITY_EN
    check("after_reset_stream", cap_tail(13), 32'h1678);
`else
    check("after_reset_stream", cap_tail(12), 32'hB3C);
`endif

    // data_valid pulse while busy must be ignored.
    cap_q.delete();
    send_word(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    data_in = 8'hFF;
    data_valid = 1'b1;
    @(negedge clk);
    #1;
    data_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
`ifdef SEQ_FRAMER_PARITY_EN
    check("ignored_len", cap_q.size(), 32'd13);
    check("ignored_stream", cap_tail(13), 32'h16B4);
`else
    check("ignored_len", cap_q.size(), 32'd12);
    check("ignored_stream", cap_tail(12), 32'hB5A);
`endif

`ifdef SEQ_FRAMER_PARITY_EN
    cap_q.delete();
    send_word(8'h07, 1'b1);
    wait_idle();
    check("parity_07", cap_tail(13), 32'h160F);
`endif

    // Randomised traffic with random gaps and held/dropped valid.
    for (int n = 0; n < 40; n++) begin
      send_word(W'($urandom), 1'($urandom_range(0, 1)));
      if (data_valid == 1'b0) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    #1;
    data_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
